// File: rtl/hatch_pkg.sv
// Shared types and constants for the hatch instruction-fetch stage.
package hatch_pkg;
  localparam int INSTR_BYTES = 6;
  localparam int INSTR_W     = 48;
  localparam int WORD_W      = 32;
  localparam int BUF_W       = 96;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // An instruction at byte offset 3 straddles three words; all others fit in two.
  function automatic logic [1:0] words_needed(input logic [1:0] offset);
    return (offset == 2'd3) ? 2'd3 : 2'd2;
  endfunction
endpackage

// File: rtl/hatch_byte_align.sv
// Picks the 6 instruction bytes out of the 12-byte word window at a byte offset.
module hatch_byte_align
  import hatch_pkg::*;
(
  input  logic [BUF_W-1:0]   window,
  input  logic [1:0]         offset,
  output logic [INSTR_W-1:0] instr
);

  logic [BUF_W-1:0] shifted;

  assign shifted = window << {offset, 3'b000};
  assign instr   = shifted[BUF_W-1 -: INSTR_W];

endmodule

// File: rtl/hatch_fetch.sv
// Unaligned 6-byte instruction fetch from a 32-bit word memory, one read outstanding.
// Optional HATCH_FETCH_REUSE_EN: reuse the last received word when the next fetch starts on it.
module hatch_fetch
  import hatch_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [31:0]        req_addr,
  output logic               req_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_addr,
  input  logic               instr_ready,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_rvalid,
  input  logic [WORD_W-1:0]  mem_rdata
);

  state_t             state;
  logic [31:0]        addr_q;
  logic [1:0]         cnt;
  logic [1:0]         cnt_inc;
  logic [BUF_W-1:0]   window;
  logic [BUF_W-1:0]   window_nxt;
  logic [INSTR_W-1:0] aligned;
  logic [ADDR_W-1:0]  req_word;

`ifdef HATCH_FETCH_REUSE_EN
  logic               tag_vld;
  logic [ADDR_W-1:0]  tag_addr;
  logic [WORD_W-1:0]  tag_dat;
`endif

  assign req_word = req_addr[ADDR_W+1:2];
  assign cnt_inc  = cnt + 2'd1;

  // Word number cnt lands at window byte 4*cnt, so the offset indexes the window directly.
  always_comb begin
    window_nxt = window;
    if (state == WAIT && mem_rvalid) begin
      case (cnt)
        2'd0:    window_nxt[95:64] = mem_rdata;
        2'd1:    window_nxt[63:32] = mem_rdata;
        default: window_nxt[31:0]  = mem_rdata;
      endcase
    end
  end

  hatch_byte_align u_align (
    .window (window_nxt),
    .offset (addr_q[1:0]),
    .instr  (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      instr_valid <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_addr  <= '0;
      addr_q      <= '0;
      cnt         <= '0;
      window      <= '0;
`ifdef HATCH_FETCH_REUSE_EN
      tag_vld     <= 1'b0;
      tag_addr    <= '0;
      tag_dat     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            req_ready <= 1'b0;
            mem_rd    <= 1'b1;
            state     <= ISSUE;
`ifdef HATCH_FETCH_REUSE_EN
            if (tag_vld && tag_addr == req_word) begin
              window   <= {tag_dat, 64'd0};
              cnt      <= 2'd1;
              mem_addr <= req_word + ADDR_W'(1);
            end else begin
              window   <= '0;
              cnt      <= 2'd0;
              mem_addr <= req_word;
            end
`else
            window   <= '0;
            cnt      <= 2'd0;
            mem_addr <= req_word;
`endif
          end
        end
        ISSUE: begin
          mem_rd <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          if (mem_rvalid) begin
            window <= window_nxt;
            cnt    <= cnt_inc;
`ifdef HATCH_FETCH_REUSE_EN
            tag_vld  <= 1'b1;
            tag_addr <= mem_addr;
            tag_dat  <= mem_rdata;
`endif
            if (cnt_inc == words_needed(addr_q[1:0])) begin
              instr_valid <= 1'b1;
              instr       <= aligned;
              instr_addr  <= addr_q;
              state       <= DONE;
            end else begin
              mem_rd   <= 1'b1;
              mem_addr <= mem_addr + ADDR_W'(1);
              state    <= ISSUE;
            end
          end
        end
        DONE: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            req_ready   <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hatch_fetch.sv
// Bench for hatch_fetch: byte-memory reference model plus directed fetches.
module tb_hatch_fetch;

  localparam bit REUSE =
`ifdef HATCH_FETCH_REUSE_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        instr_valid;
  logic [47:0] instr;
  logic [31:0] instr_addr;
  logic        instr_ready = 1'b0;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        b_req_valid = 1'b0;
  logic [31:0] b_req_addr = '0;
  logic        b_req_ready;
  logic        b_instr_valid;
  logic [47:0] b_instr;
  logic [31:0] b_instr_addr;
  logic        b_instr_ready = 1'b1;
  logic        b_mem_rd;
  logic [3:0]  b_mem_addr;
  logic        b_mem_rvalid = 1'b0;
  logic [31:0] b_mem_rdata = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hatch_fetch #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_addr(instr_addr), .instr_ready(instr_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  hatch_fetch #(.ADDR_W(4)) dut_small (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
    .instr_valid(b_instr_valid), .instr(b_instr), .instr_addr(b_instr_addr), .instr_ready(b_instr_ready),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory byte k holds k[7:0]; a word is four consecutive bytes, big-endian.
  function automatic logic [31:0] word_of(input int w);
    return {8'((4*w) & 255), 8'((4*w+1) & 255), 8'((4*w+2) & 255), 8'((4*w+3) & 255)};
  endfunction

  // Six bytes from a byte address in a space of 2^(aw+2) bytes.
  function automatic logic [47:0] exp_bytes(input int a, input int aw);
    logic [47:0] r = '0;
    for (int i = 0; i < 6; i++)
      r = {r[39:0], 8'(((a + i) % (1 << (aw + 2))) & 255)};
    return r;
  endfunction

  // Reference model state
  int          exp_words[$];
  logic [47:0] exp_instr = '0;
  logic [31:0] exp_addr = '0;
  int          last_word = 0;
  bit          last_vld = 1'b0;
  int          lat = 1;
  int          pend = 0;
  int          paddr = 0;
  bit          inject = 1'b0;
  bit          prev_rd = 1'b0;
  int          pulses = 0;

  task automatic model_request(input logic [31:0] a);
    int first, n, start;
    first = (a >> 2) & 16'hFFFF;
    n = (a[1:0] == 2'd3) ? 3 : 2;
    start = (REUSE && last_vld && last_word == first) ? 1 : 0;
    for (int i = start; i < n; i++) exp_words.push_back((first + i) & 16'hFFFF);
    exp_instr = exp_bytes(a, 16);
    exp_addr = a;
  endtask

  // Per-cycle compare against the model, then the memory responder.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd) begin
        pulses++;
        chk("mem_rd_one_cycle", 64'(prev_rd), 64'd0);
        if (exp_words.size() == 0) chk("mem_rd_unexpected", 64'(mem_addr), 64'hFFFF_FFFF);
        else chk("mem_addr", 64'(mem_addr), 64'(exp_words.pop_front()));
      end
      if (instr_valid) begin
        chk("instr", 64'(instr), 64'(exp_instr));
        chk("instr_addr", 64'(instr_addr), 64'(exp_addr));
        chk("req_ready_busy", 64'(req_ready), 64'd0);
      end
    end
    prev_rd = mem_rd;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    if (inject) begin
      mem_rvalid = 1'b1;
      mem_rdata = 32'hDEADBEEF;
    end
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = word_of(paddr);
        last_word = paddr;
        last_vld = 1'b1;
      end
    end
    if (mem_rd) begin
      pend = lat;
      paddr = int'(mem_addr);
    end
  end

  int  b_addrs[$];
  bit  b_pend = 1'b0;
  int  b_paddr = 0;

  always @(negedge clk) begin
    b_mem_rvalid = 1'b0;
    b_mem_rdata = '0;
    if (b_pend) begin
      b_mem_rvalid = 1'b1;
      b_mem_rdata = word_of(b_paddr);
      b_pend = 1'b0;
    end
    if (b_mem_rd && !rst) begin
      b_pend = 1'b1;
      b_paddr = int'(b_mem_addr);
      b_addrs.push_back(int'(b_mem_addr));
    end
  end

  task automatic fetch(input logic [31:0] a, input int hold, output logic [47:0] got);
    int t;
    got = '0;
    instr_ready = (hold == 0);
    t = 0;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    if (!req_ready) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    model_request(a);
    req_valid = 1'b1;
    req_addr = a;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!instr_valid && t < 300) begin @(negedge clk); t++; end
    if (!instr_valid) begin
      chk("instr_valid_timeout", 64'(instr_valid), 64'd1);
      return;
    end
    got = instr;
    repeat (hold) @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    if (hold > 0) instr_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pend = 0;
    exp_words.delete();
    last_vld = 1'b0;
  endtask

  initial begin
    logic [47:0] got;
    int p0, t;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_addr", 64'(instr_addr), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Aligned fetch
    p0 = pulses;
    fetch(32'h00, 0, got);
    chk("instr_0x00", 64'(got), 64'h0000_0001_0203_0405);
    chk("pulses_0x00", 64'(pulses - p0), 64'd2);

    // Offset-3 fetch spans three words
    p0 = pulses;
    fetch(32'h13, 0, got);
    chk("instr_0x13", 64'(got), 64'h0000_1314_1516_1718);
    chk("pulses_0x13", 64'(pulses - p0), 64'd3);

    // Slow memory with consumer backpressure
    lat = 3;
    fetch(32'h06, 5, got);
    chk("instr_0x06_slow", 64'(got), 64'h0000_0607_0809_0A0B);
    lat = 1;

    // Reset mid-WAIT, then a stale response in IDLE
    lat = 10;
    model_request(32'h00);
    req_valid = 1'b1;
    req_addr = 32'h00;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    do_reset();
    inject = 1'b1;
    repeat (2) @(negedge clk);
    inject = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_instr_valid", 64'(instr_valid), 64'd0);
      chk("abort_req_ready", 64'(req_ready), 64'd1);
      @(negedge clk);
    end
    lat = 1;
    fetch(32'h00, 0, got);
    chk("instr_after_abort", 64'(got), 64'h0000_0001_0203_0405);

    // Back-to-back sequential fetches
    do_reset();
    p0 = pulses;
    fetch(32'h00, 0, got);
    chk("b2b_first", 64'(got), 64'h0000_0001_0203_0405);
    fetch(32'h06, 0, got);
    chk("b2b_second", 64'(got), 64'h0000_0607_0809_0A0B);
    chk("b2b_pulses", 64'(pulses - p0), REUSE ? 64'd3 : 64'd4);

    // Word-address wrap on the narrow instance
    b_addrs.delete();
    b_req_valid = 1'b1;
    b_req_addr = 32'h3F;
    @(negedge clk);
    b_req_valid = 1'b0;
    t = 0;
    while (!b_instr_valid && t < 300) begin @(negedge clk); t++; end
    chk("wrap_valid", 64'(b_instr_valid), 64'd1);
    chk("wrap_instr", 64'(b_instr), 64'h0000_3F00_0102_0304);
    chk("wrap_instr_model", 64'(b_instr), 64'(exp_bytes(32'h3F, 4)));
    chk("wrap_instr_addr", 64'(b_instr_addr), 64'h3F);
    chk("wrap_nreads", 64'(b_addrs.size()), 64'd3);
    if (b_addrs.size() == 3) begin
      chk("wrap_word0", 64'(b_addrs[0]), 64'hF);
      chk("wrap_word1", 64'(b_addrs[1]), 64'h0);
      chk("wrap_word2", 64'(b_addrs[2]), 64'h1);
    end
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule
